// File: rtl/fsm_mon_pkg.sv
// fsm_mon_pkg: shared state/event types for the dwell monitor
package fsm_mon_pkg;
  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;
  typedef enum logic {M_PRIME, M_TRACK} mode_t;
  typedef struct packed {
    state_t from;
    state_t to;
  } ev_hdr_t;
  function automatic int ev_w(input int dw);
    return $bits(ev_hdr_t) + dw;
  endfunction
endpackage

// File: rtl/fsm_mon_fifo.sv
// fsm_mon_fifo: first-word fall-through event FIFO; a push into a full FIFO is taken only alongside a pop
module fsm_mon_fifo
  import fsm_mon_pkg::*;
#(
  parameter int W = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign rd = pop & ~empty;
  assign wr = push & (~full | rd);
  assign dout = empty ? '0 : mem[rp];
  // storage array, written at the tail
  always_ff @(posedge clock) begin
    if (wr) mem[wp] <= din;
  end
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/fsm_dwell_mon.sv
// fsm_dwell_mon: logs state transitions with dwell time; timeout logic built only with FSM_DWELL_MON_TIMEOUT_EN
module fsm_dwell_mon
  import fsm_mon_pkg::*;
#(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  state_t                 st,
  input  logic [DW-1:0]          limit,
  input  logic                   clr,
  output logic                   trans,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output state_t                 ev_from,
  output state_t                 ev_to,
  output logic [DW-1:0]          ev_dwell,
  output logic [$clog2(DEPTH):0] count,
  output logic                   timeout,
  output logic                   ovf
);
  localparam int EW = ev_w(DW);
  typedef struct packed {
    state_t from;
    state_t to;
    logic [DW-1:0] dwell;
  } ev_t;
  mode_t mode, mode_nx;
  state_t prev, prev_nx;
  logic [DW-1:0] dwell, dwell_nx;
  logic primed, is_trans, pop, full, empty, drop;
  ev_t ev_in, ev_out;
  assign primed = mode == M_TRACK;
  assign ev_valid = ~empty;
  assign pop = ev_valid & ev_ready;
  assign drop = is_trans & full & ~pop;
  assign ev_from = ev_out.from;
  assign ev_to = ev_out.to;
  assign ev_dwell = ev_out.dwell;
  // next tracking state: prime on first step, restart dwell on change, else count up saturating
  always_comb begin
    mode_nx = en ? M_TRACK : mode;
    is_trans = en & primed & (st != prev);
    prev_nx = en ? st : prev;
    dwell_nx = !en ? dwell : (is_trans | !primed) ? DW'(1) : (&dwell) ? dwell : dwell + DW'(1);
    ev_in = '{from: prev, to: st, dwell: dwell};
  end
  // tracking state register
  always_ff @(posedge clock) begin
    if (reset) begin
      mode <= M_PRIME;
      prev <= '0;
      dwell <= '0;
      trans <= 1'b0;
    end else begin
      mode <= mode_nx;
      prev <= prev_nx;
      dwell <= dwell_nx;
      trans <= is_trans;
    end
  end
  // sticky overflow: a dropped event outranks clr
  always_ff @(posedge clock) begin
    if (reset) ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
    else if (clr) ovf <= 1'b0;
  end
`ifdef FSM_DWELL_MON_TIMEOUT_EN
  // sticky timeout: transition clears, long dwell sets, then clr clears
  always_ff @(posedge clock) begin
    if (reset) timeout <= 1'b0;
    else if (is_trans) timeout <= 1'b0;
    else if (primed && limit != '0 && dwell >= limit) timeout <= 1'b1;
    else if (clr) timeout <= 1'b0;
  end
`else
  logic unused_limit;
  assign unused_limit = ^limit;
  assign timeout = 1'b0;
`endif
  fsm_mon_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(is_trans),
    .pop(pop),
    .din(ev_in),
    .dout(ev_out),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_fsm_dwell_mon.sv
// tb_fsm_dwell_mon: directed and random stimulus against a queue-based event model
module tb_fsm_dwell_mon;
  localparam int DW = 4;
  localparam int DEPTH = 4;
  localparam int MAXD = (1 << DW) - 1;
`ifdef FSM_DWELL_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef struct {
    int f;
    int t;
    int d;
  } ev_s;
  logic clock = 1'b0;
  logic reset, en, clr, ev_ready;
  logic [2:0] st;
  logic [DW-1:0] limit;
  logic trans, ev_valid, timeout, ovf;
  logic [2:0] ev_from, ev_to;
  logic [DW-1:0] ev_dwell;
  logic [$clog2(DEPTH):0] count;
  int n_tests = 0;
  int n_fail = 0;
  ev_s q[$];
  bit m_primed, m_trans, m_ovf, m_to;
  int m_prev, m_dwell;
  fsm_dwell_mon #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .en(en),
    .st(st),
    .limit(limit),
    .clr(clr),
    .trans(trans),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_from(ev_from),
    .ev_to(ev_to),
    .ev_dwell(ev_dwell),
    .count(count),
    .timeout(timeout),
    .ovf(ovf)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic model();
    bit chg, popped;
    ev_s e;
    if (reset) begin
      q.delete();
      m_primed = 0;
      m_trans = 0;
      m_ovf = 0;
      m_to = 0;
      m_prev = 0;
      m_dwell = 0;
      return;
    end
    chg = en && m_primed && (int'(st) != m_prev);
    popped = ev_ready && q.size() > 0;
    if (chg) m_to = 0;
    else if (m_primed && limit != 0 && m_dwell >= int'(limit)) m_to = 1;
    else if (clr) m_to = 0;
    if (chg && q.size() == DEPTH && !popped) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (popped) void'(q.pop_front());
    if (chg && q.size() < DEPTH) begin
      e.f = m_prev;
      e.t = st;
      e.d = m_dwell;
      q.push_back(e);
    end
    if (en) begin
      m_dwell = (!m_primed || chg) ? 1 : (m_dwell + 1 > MAXD ? MAXD : m_dwell + 1);
      m_prev = st;
      m_primed = 1;
    end
    m_trans = chg;
  endtask
  task automatic check_all();
    chk("trans", trans, m_trans);
    chk("ev_valid", ev_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("ovf", ovf, m_ovf);
    chk("timeout", timeout, TO_EN && m_to);
    if (q.size() != 0) begin
      chk("ev_from", ev_from, q[0].f);
      chk("ev_to", ev_to, q[0].t);
      chk("ev_dwell", ev_dwell, q[0].d);
    end
  endtask
  task automatic cyc(input bit r, input bit e, input int s, input bit c, input bit rdy);
    reset = r;
    en = e;
    st = 3'(s);
    clr = c;
    ev_ready = rdy;
    @(posedge clock);
    model();
    @(negedge clock);
    check_all();
  endtask
  initial begin
    limit = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("rst_from", ev_from, 0);
    chk("rst_to", ev_to, 0);
    chk("rst_dwell", ev_dwell, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 3, 0, 0);
    cyc(0, 1, 5, 0, 0);
    chk("s1_trans", trans, 1);
    chk("s1_count", count, 1);
    chk("s1_from", ev_from, 3);
    chk("s1_to", ev_to, 5);
    chk("s1_dwell", ev_dwell, 5);
    cyc(0, 0, 5, 0, 0);
    chk("s1_trans_end", trans, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 2, 0, 0);
      cyc(0, 0, 2, 0, 0);
    end
    cyc(0, 1, 6, 0, 0);
    chk("s2_dwell", ev_dwell, 4);
    cyc(1, 0, 0, 0, 0);
    limit = DW'(3);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0);
    chk("s3_to_set", timeout, TO_EN);
    cyc(0, 1, 1, 1, 0);
    chk("s3_to_clr_held", timeout, TO_EN);
    cyc(0, 1, 4, 0, 0);
    chk("s3_to_trans", timeout, 0);
    limit = '0;
    cyc(1, 0, 0, 0, 0);
    for (int s = 0; s < 6; s++) cyc(0, 1, s, 0, 0);
    chk("s4_count", count, 4);
    chk("s4_ovf", ovf, 1);
    cyc(0, 0, 5, 1, 0);
    chk("s4_ovf_clr", ovf, 0);
    cyc(0, 1, 6, 0, 1);
    chk("s4_full_pp_count", count, 4);
    chk("s4_full_pp_ovf", ovf, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 6, 0, 1);
    chk("s4_drained", ev_valid, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 7, 0, 0);
    chk("s5_sat", ev_dwell, MAXD);
    cyc(1, 0, 0, 0, 0);
    limit = DW'(1);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 2, 0, 0);
    cyc(0, 1, 3, 0, 0);
    cyc(0, 1, 3, 0, 0);
    chk("s6_to_pre", timeout, TO_EN);
    chk("s6_count_pre", count, 2);
    cyc(1, 1, 5, 0, 0);
    chk("s6_count_rst", count, 0);
    chk("s6_to_rst", timeout, 0);
    chk("s6_from_rst", ev_from, 0);
    cyc(0, 1, 6, 0, 0);
    chk("s6_prime_trans", trans, 0);
    chk("s6_prime_count", count, 0);
    limit = '0;
    for (int i = 0; i < 3000; i++) begin
      int s;
      if (i % 64 == 0) limit = DW'($urandom_range(0, 5));
      s = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 7)) : int'(st);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, s,
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
